prng_range: RTL and testbench
=============================

# prng_range

Parametrised pseudo-random number source for the game logic: platform x positions, spawn gaps, enemy selection. A free-running Fibonacci XNOR LFSR of configurable width and taps, with all-ones lock-up escape and optional runtime seeding. A request/valid front end uses bounded rejection sampling to return values uniformly in `[0, RANGE)`. It feeds the platform generator and any other consumer that needs a bounded random draw per request.

## Interface
Parameters:
- `WIDTH`, 16: LFSR state width, 4..32.
- `TAPS`, 16'hB400: feedback tap mask. Bit i set means `state[i]` feeds the XNOR. The default is maximal-length for 16 bits.
- `RANGE`, 640: exclusive upper bound of drawn values. Must satisfy 2^(OUT_W-1) < RANGE ≤ 2^OUT_W.
- `OUT_W`, 10: drawn value width. Must be ≤ WIDTH.
- `MAX_TRIES`, 8: rejection attempts before fallback, 1..15.

Ports:
- `Clk` in 1: single clock.
- `Reset` in 1: synchronous, active-high.
- `seed_load` in 1: load `seed_in` into the LFSR on the next edge.
- `seed_in` in WIDTH: seed value.
- `req` in 1: draw request. Sampled only in IDLE.
- `busy` out 1: high while in DRAW.
- `valid` out 1: one-cycle pulse. `value` is new.
- `value` out OUT_W: drawn number, always < RANGE. Held until the next valid.
- `raw` out WIDTH: current LFSR state, for debug and auxiliary bits.

## Operation
- LFSR steps on every edge, independent of FSM. Player timing of `req` supplies entropy.
- Step rule: `state <= {state[WIDTH-2:0], fb}`.
  - `fb` is the XNOR reduction of `state & TAPS`.
  - When `state` is all-ones, `fb` is the XOR reduction instead (lock-up escape).
- `seed_load` overrides stepping on that edge. Priority: Reset > seed_load > step.
- Sample is `state[OUT_W-1:0]`, taken from the current, pre-step state.
- FSM states: IDLE, DRAW.
  - IDLE, `req`=1 → DRAW, `tries` ← 0.
  - DRAW, sample < RANGE → `value` ← sample, `valid` ← 1, go to IDLE.
  - DRAW, sample ≥ RANGE, `tries` < MAX_TRIES-1 → `tries`+1, stay in DRAW.
  - DRAW, sample ≥ RANGE, `tries` = MAX_TRIES-1 → `value` ← sample − RANGE (guaranteed < RANGE by the parameter constraint), `valid` ← 1, go to IDLE.
- `req` in DRAW is ignored, not queued.
- Reset mid-DRAW aborts the draw. No `valid` is produced.
- `seed_load` during DRAW: the draw continues and samples the loaded state on the following cycle.

## Timing
- Reset values: `state` = 0, FSM = IDLE, `tries` = 0, `valid` = 0, `value` = 0, `busy` = 0, `raw` = 0.
- `valid` and `value` are registered.
- `req` high at edge k → `busy` high after k.
- `valid` high after edge k+n, n ∈ [1, MAX_TRIES]. Latency is 2..MAX_TRIES+1 cycles from `req` assertion.
- `busy` falls on the same edge `valid` rises.
- `req` held high gives back-to-back draws. `req` is accepted in the cycle `valid` is high, since the FSM is then in IDLE.
- Throughput is at most one draw per 2 cycles.

## Configuration
- `PRNG_SEED_LOAD_EN` defined: `seed_load`/`seed_in` behave as above.
- `PRNG_SEED_LOAD_EN` undefined: ports remain but are ignored. The LFSR only resets to 0 and steps, giving a deterministic sequence for replay and regression.

## Structure
- Package `prng_pkg`:
  - FSM state enum (`PRNG_IDLE`, `PRNG_DRAW`).
  - Default `WIDTH`/`TAPS` constants for 9, 16 and 32 bits: 9'h110, 16'hB400, 32'h80200003.
  - `tries` counter width constant (4).
- Sub-module `lfsr_core`:
  - Parameters: WIDTH, TAPS.
  - Ports: Clk, Reset, load, load_val, state.
  - Contains the step rule and lock-up escape. `prng_range` instantiates it once and adds the FSM and range logic.

## Test plan
- Reset, then free-run with defaults → `raw` = 0x0000, 0x0001, 0x0003, 0x0007 on successive edges.
- `seed_load`=1 with `seed_in`=16'hFFFF (macro on) → next `raw` = 16'hFFFF, then 16'hFFFE. Never stuck.
- Seed so that sample = 10'd100 on the first DRAW cycle, pulse `req` → `valid` 2 cycles after `req`, `value` = 100, `busy` high exactly 1 cycle.
- Seed so that the first 3 samples are ≥ 640 (e.g. 1000, 700, 900) and the 4th is 5 → `valid` after 5 cycles, `value` = 5.
- Hold `req` for 10 000 cycles → every `value` < 640, no `valid` gap beyond MAX_TRIES+1, histogram roughly flat.
- Assert Reset while in DRAW → next cycle `busy`=0, `valid`=0, `raw`=0. Macro off: `seed_load` has no effect on `raw`.

Source files
------------

// File: rtl/prng_pkg.sv
// Shared types and constants for the bounded pseudo-random draw source.
// Holds the FSM encoding, tap masks known to be maximal-length, and the tries-counter width.
package prng_pkg;

    typedef enum logic [0:0] {
        PRNG_IDLE = 1'b0,
        PRNG_DRAW = 1'b1
    } prng_state_e;

    localparam int          PRNG_WIDTH_9  = 9;
    localparam logic [8:0]  PRNG_TAPS_9   = 9'h110;
    localparam int          PRNG_WIDTH_16 = 16;
    localparam logic [15:0] PRNG_TAPS_16  = 16'hB400;
    localparam int          PRNG_WIDTH_32 = 32;
    localparam logic [31:0] PRNG_TAPS_32  = 32'h8020_0003;

    localparam int PRNG_TRIES_W = 4;

endpackage

// File: rtl/prng_range_if.sv
// Request/valid bundle between a random-number consumer (master) and prng_range (slave).
// The consumer owns req and the seed inputs; the source returns busy/valid/value plus the raw LFSR state.
interface prng_range_if #(
    parameter int WIDTH = 16,
    parameter int OUT_W = 10
);
    logic             seed_load;
    logic [WIDTH-1:0] seed_in;
    logic             req;
    logic             busy;
    logic             valid;
    logic [OUT_W-1:0] value;
    logic [WIDTH-1:0] raw;

    modport master (
        output seed_load, seed_in, req,
        input  busy, valid, value, raw
    );

    modport slave (
        input  seed_load, seed_in, req,
        output busy, valid, value, raw
    );
endinterface

// File: rtl/prng_range_lfsr_core.sv
// Free-running Fibonacci XNOR LFSR; steps every cycle, load overrides the step.
// The all-ones state (the XNOR lock-up) switches feedback to XOR so the register always escapes.
module lfsr_core #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state
);
    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] masked;
    logic             fb;

    always_comb begin
        masked  = state_q & TAPS;
        fb      = (&state_q) ? (^masked) : ~(^masked);
        state_d = {state_q[WIDTH-2:0], fb};
        if (load) begin
            state_d = load_val;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/prng_range.sv
// Bounded random draw: LFSR sample rejected while >= RANGE, folded by -RANGE on the last try; valid 2..MAX_TRIES+1 cycles after req.
// req is only taken in IDLE (one draw in flight, no queueing); runtime seeding exists only when PRNG_SEED_LOAD_EN is defined.
module prng_range
    import prng_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = PRNG_TAPS_16,
    parameter int               RANGE     = 640,
    parameter int               OUT_W     = 10,
    parameter int               MAX_TRIES = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    prng_range_if.slave bus
);
    localparam logic [OUT_W:0]        RANGE_W  = (OUT_W+1)'(RANGE);
    localparam logic [PRNG_TRIES_W-1:0] LAST_TRY = PRNG_TRIES_W'(MAX_TRIES - 1);

    logic             lfsr_load;
    logic [WIDTH-1:0] lfsr_load_val;
    logic [WIDTH-1:0] lfsr_state;

`ifdef PRNG_SEED_LOAD_EN
    assign lfsr_load     = bus.seed_load;
    assign lfsr_load_val = bus.seed_in;
`else
    logic unused_seed;
    assign unused_seed   = ^{bus.seed_load, bus.seed_in};
    assign lfsr_load     = 1'b0;
    assign lfsr_load_val = '0;
`endif

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_lfsr (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .state    (lfsr_state)
    );

    prng_state_e            state_q, state_d;
    logic [PRNG_TRIES_W-1:0] tries_q, tries_d;
    logic                   valid_q, valid_d;
    logic [OUT_W-1:0]       value_q, value_d;

    logic [OUT_W-1:0] sample;
    logic             in_range;
    logic [OUT_W-1:0] folded;

    // Fold is exact: RANGE > 2^(OUT_W-1) keeps sample-RANGE below RANGE.
    assign sample   = lfsr_state[OUT_W-1:0];
    assign in_range = {1'b0, sample} < RANGE_W;
    assign folded   = sample - RANGE_W[OUT_W-1:0];

    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        valid_d = 1'b0;
        value_d = value_q;
        case (state_q)
            PRNG_IDLE: begin
                if (bus.req) begin
                    state_d = PRNG_DRAW;
                    tries_d = '0;
                end
            end
            PRNG_DRAW: begin
                if (in_range) begin
                    value_d = sample;
                    valid_d = 1'b1;
                    state_d = PRNG_IDLE;
                end else if (tries_q == LAST_TRY) begin
                    value_d = folded;
                    valid_d = 1'b1;
                    state_d = PRNG_IDLE;
                end else begin
                    tries_d = tries_q + 1'b1;
                end
            end
            default: state_d = PRNG_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= PRNG_IDLE;
            tries_q <= '0;
            valid_q <= 1'b0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            valid_q <= valid_d;
            value_q <= value_d;
        end
    end

    assign bus.busy  = (state_q == PRNG_DRAW);
    assign bus.valid = valid_q;
    assign bus.value = value_q;
    assign bus.raw   = lfsr_state;

endmodule

// File: tb/tb_prng_range.sv
// Directed bench for prng_range with default parameters, walking the known LFSR sequence from reset.
module tb_prng_range;
    logic clk = 1'b0;
    logic rst = 1'b1;

    prng_range_if #(.WIDTH(16), .OUT_W(10)) bus ();

    prng_range dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        int gap;
        int draws;
        int low_half;
        bus.req       = 1'b0;
        bus.seed_load = 1'b0;
        bus.seed_in   = 16'h0000;

        // Reset state
        tick();
        tick();
        chk("rst_raw",   bus.raw,   16'h0000);
        chk("rst_busy",  bus.busy,  1'b0);
        chk("rst_valid", bus.valid, 1'b0);
        chk("rst_value", bus.value, 10'd0);
        rst = 1'b0;

        // Free-run from zero: 0, 1, 3, 7
        tick();
        chk("run_s1", bus.raw, 16'h0001);
        tick();
        chk("run_s2", bus.raw, 16'h0003);
        tick();
        chk("run_s3", bus.raw, 16'h0007);

        // Immediate accept: first DRAW sample is 0x1FF = 511
        repeat (5) tick();
        bus.req = 1'b1;
        tick();
        chk("acc_busy",  bus.busy,  1'b1);
        chk("acc_valid", bus.valid, 1'b0);
        chk("acc_raw",   bus.raw,   16'h01FF);
        bus.req = 1'b0;
        tick();
        chk("acc_valid1", bus.valid, 1'b1);
        chk("acc_value",  bus.value, 10'd511);
        chk("acc_busy0",  bus.busy,  1'b0);
        chk("acc_raw1",   bus.raw,   16'h03FF);
        tick();
        chk("acc_pulse", bus.valid, 1'b0);
        chk("acc_hold",  bus.value, 10'd511);

        // Reset mid-draw (samples 1022/1020 are rejected)
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        tick();
        chk("abort_busy_pre", bus.busy, 1'b1);
        rst = 1'b1;
        tick();
        chk("abort_busy",  bus.busy,  1'b0);
        chk("abort_valid", bus.valid, 1'b0);
        chk("abort_raw",   bus.raw,   16'h0000);
        chk("abort_value", bus.value, 10'd0);
        rst = 1'b0;

        // Fallback: samples 1023,1023,1022,1020,1017,1010,996,969 -> 969-640 = 329
        repeat (9) tick();
        bus.req = 1'b1;
        tick();
        chk("fb_raw", bus.raw, 16'h03FF);
        bus.req = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("fb_busy",  bus.busy,  1'b1);
            chk("fb_valid", bus.valid, 1'b0);
        end
        tick();
        chk("fb_valid1", bus.valid, 1'b1);
        chk("fb_value",  bus.value, 10'd329);
        chk("fb_busy0",  bus.busy,  1'b0);

        // Three rejects (969, 915, 807) then 591 accepted: latency 5 cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (16) tick();
        bus.req = 1'b1;
        tick();
        chk("rej_raw", bus.raw, 16'hFFC9);
        bus.req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rej_busy",  bus.busy,  1'b1);
            chk("rej_valid", bus.valid, 1'b0);
        end
        tick();
        chk("rej_valid1", bus.valid, 1'b1);
        chk("rej_value",  bus.value, 10'd591);

        // Back-to-back with req held, accepted in the valid cycle
        bus.req = 1'b1;
        tick();
        chk("b2b_busy1",  bus.busy,  1'b1);
        chk("b2b_valid1", bus.valid, 1'b0);
        tick();
        chk("b2b_v1",     bus.valid, 1'b1);
        chk("b2b_value1", bus.value, 10'd319);
        tick();
        chk("b2b_busy2",  bus.busy,  1'b1);
        tick();
        chk("b2b_v2",     bus.valid, 1'b1);
        chk("b2b_value2", bus.value, 10'd252);

        // Seed load: effective only with PRNG_SEED_LOAD_EN
        bus.req       = 1'b0;
        bus.seed_load = 1'b1;
        bus.seed_in   = 16'hFFFF;
        tick();
        bus.seed_load = 1'b0;
`ifdef PRNG_SEED_LOAD_EN
        chk("seed_raw",   bus.raw, 16'hFFFF);
        tick();
        chk("seed_escape", bus.raw, 16'hFFFE);
`else
        chk("seed_ignored",  bus.raw, 16'h93F0);
        tick();
        chk("seed_ignored2", bus.raw, 16'h27E1);
`endif

        // Soak with req held: range, latency bound, rough balance
        gap      = 0;
        draws    = 0;
        low_half = 0;
        bus.req  = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            tick();
            gap++;
            if (bus.valid) begin
                chk("soak_range", bus.value < 10'd640, 1'b1);
                chk("soak_gap", (gap >= 2) && (gap <= 9), 1'b1);
                if (bus.value < 10'd320) low_half++;
                draws++;
                gap = 0;
            end else if (gap > 9) begin
                chk("soak_timeout", gap, 9);
                gap = 0;
            end
        end
        bus.req = 1'b0;
        chk("soak_draws", draws > 500, 1'b1);
        chk("soak_low_bal",  low_half * 100 > draws * 35, 1'b1);
        chk("soak_high_bal", (draws - low_half) * 100 > draws * 35, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
